// File: rtl/sr_pulse_gen.sv
// Set/clear request conditioner: synchronizes and debounces two raw buttons and
// turns each qualified press into a one-cycle, mutually exclusive strobe.
module sr_pulse_gen #(
   parameter int DEBOUNCE_CNT = 16,
   parameter int CNT_W        = 5
) (
   input  logic clk,
   input  logic n_rst,
   input  logic btn_set,
   input  logic btn_clr,
   output logic set_pulse,
   output logic clr_pulse,
   output logic conflict,
   output logic set_level,
   output logic clr_level
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

   // Channel index 0 is set, 1 is clear throughout.
   logic [1:0]       sync1;
   logic [1:0]       sync2;
   logic [1:0]       stable;
   logic [1:0]       stable_d;
   logic [1:0]       rise;
   logic [CNT_W-1:0] cnt [2];

   // Two-flop synchronizer
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {btn_clr, btn_set};
         sync2 <= sync1;
      end
   end

   // Debounce: the synchronized level must disagree with the stable state for
   // DEBOUNCE_CNT consecutive cycles; any agreement restarts the count.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         stable <= '0;
         cnt[0] <= '0;
         cnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               stable[i] <= sync2[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign rise = stable & ~stable_d;

   // Edge detect and arbitration: simultaneous presses are dropped and flagged
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         stable_d  <= '0;
         set_pulse <= 1'b0;
         clr_pulse <= 1'b0;
         conflict  <= 1'b0;
      end else begin
         stable_d  <= stable;
         set_pulse <= rise[0] & ~rise[1];
         clr_pulse <= rise[1] & ~rise[0];
         conflict  <= rise[0] & rise[1];
      end
   end

   assign set_level = stable[0];
   assign clr_level = stable[1];

endmodule
